// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and parity type selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the data word with even/odd select.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    // Odd parity inverts the even-parity result.
    assign parity_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a word when the FIFO is non-empty and sends
// start, LSB-first data, optional parity and one stop bit on TX_OUT.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Empty,
    input  logic [DATA_WIDTH-1:0] D_IN,
    input  logic                  D_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  Rd_Req,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Frame_Done
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    tx_state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d;
    logic                    par_en_q, par_en_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    rd_req_q, rd_req_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    par_calc;
    logic                    cnt_last;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (D_IN),
        .par_typ_i (PAR_TYP),
        .parity_o  (par_calc)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state, bit timing, shifter and registered output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        tx_d     = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!Empty) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (D_Valid) begin
                    sh_d     = D_IN;
                    par_en_d = PAR_EN;
                    par_d    = par_calc;
                    tx_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (par_en_q) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = Empty ? ST_IDLE : ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        rd_req_d = (state_d == ST_FETCH);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
    end

    // State and datapath registers; reset idles the line high and drops any word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            rd_req_q <= rd_req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Rd_Req     = rd_req_q;
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;
    assign Frame_Done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench for fifo_uart_tx with a behavioural FIFO read port.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pb;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Empty;
    logic [7:0] D_IN;
    logic       D_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Rd_Req;
    logic       TX_OUT;
    logic       Busy;
    logic       Frame_Done;

    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   tx_low_cnt = 0;
    int   frames_seen = 0;
    int   last_gap = 0;
    int   last_gap_low = 0;
    logic mon_en = 1'b0;
    logic mon_busy = 1'b0;
    logic drop_valid = 1'b0;

    logic [7:0] fq[$];
    exp_t       exp_q[$];

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Empty      (Empty),
        .D_IN       (D_IN),
        .D_Valid    (D_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Rd_Req     (Rd_Req),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .Frame_Done (Frame_Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO read port: a request seen at an edge returns data with a one-cycle valid strobe.
    initial begin : fifo_model
        logic req;
        Empty   = 1'b1;
        D_Valid = 1'b0;
        D_IN    = 8'h00;
        forever begin
            @(posedge CLK);
            req = Rd_Req;
            #1;
            D_Valid = 1'b0;
            if (req === 1'b1 && fq.size() > 0 && !drop_valid) begin
                D_IN    = fq.pop_front();
                D_Valid = 1'b1;
            end
            Empty = (fq.size() == 0);
        end
    end

    // Event counters sampled on the inactive edge.
    always @(negedge CLK) begin
        if (Rd_Req === 1'b1)     rd_cnt     <= rd_cnt + 1;
        if (Frame_Done === 1'b1) done_cnt   <= done_cnt + 1;
        if (TX_OUT === 1'b0)     tx_low_cnt <= tx_low_cnt + 1;
    end

    // Monitor: on each start edge pop the expected frame and compare the whole line waveform.
    initial begin : monitor
        exp_t        e;
        logic [11:0] bits;
        logic        prev;
        int          len, bad, dbad, mcyc, end_cyc, gap_low;
        logic        aborted;
        prev = 1'b1; mcyc = 0; end_cyc = 0; gap_low = 0;
        forever begin
            @(negedge CLK);
            mcyc++;
            if (mon_en && !RST && prev === 1'b1 && TX_OUT === 1'b0) begin
                last_gap     = mcyc - end_cyc - 1;
                last_gap_low = gap_low;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e    = exp_q.pop_front();
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
                    if (e.pe) bits[9] = e.pb;
                    len  = (e.pe ? 11 : 10) * CPB;
                    bad = 0; dbad = 0; aborted = 1'b0;
                    mon_busy = 1'b1;
                    for (int c = 0; c < len; c++) begin
                        if (c > 0) begin
                            @(negedge CLK);
                            mcyc++;
                        end
                        if (!mon_en || RST) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (TX_OUT !== bits[c / CPB]) bad++;
                        if (Busy !== 1'b1) bad++;
                        if (Frame_Done !== 1'(c == len - 1)) dbad++;
                    end
                    if (!aborted) begin
                        check($sformatf("frame_%02h_line", e.data), 32'(bad), 32'd0);
                        check($sformatf("frame_%02h_done", e.data), 32'(dbad), 32'd0);
                        frames_seen++;
                        end_cyc = mcyc;
                    end
                    mon_busy = 1'b0;
                end
                gap_low = 0;
            end else if (Busy === 1'b0) begin
                gap_low++;
            end
            prev = TX_OUT;
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pb);
        exp_t e;
        e.data = d; e.pe = pe; e.pb = pb;
        exp_q.push_back(e);
        fq.push_back(d);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (frames_seen < target) check("wait_frames_timeout", 32'(frames_seen), 32'(target));
        repeat (4) @(negedge CLK);
    endtask

    initial begin : stimulus
        int n, rd0, done0, txl0, fs;
        RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {28'd0, TX_OUT, Rd_Req, Busy, Frame_Done}, 32'b1000);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset mid-frame: word is lost, line snaps high.
        send(8'hA5, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        n = 0;
        while (TX_OUT !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (TX_OUT !== 1'b0) check("reset_test_start_timeout", 32'(TX_OUT), 32'd0);
        repeat (12) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midframe_reset_outputs", {28'd0, TX_OUT, Rd_Req, Busy, Frame_Done}, 32'b1000);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rd0 = rd_cnt; txl0 = tx_low_cnt;
        repeat (20) @(negedge CLK);
        check("post_reset_rd_req", 32'(rd_cnt - rd0), 32'd0);
        check("post_reset_tx_quiet", 32'(tx_low_cnt - txl0), 32'd0);
        mon_en = 1'b1;

        // Basic 8N1 frame of 0xA5.
        rd0 = rd_cnt; done0 = done_cnt; fs = frames_seen;
        send(8'hA5, 1'b0, 1'b0);
        wait_frames(fs + 1, 200);
        check("basic_rd_req_count", 32'(rd_cnt - rd0), 32'd1);
        check("basic_done_count", 32'(done_cnt - done0), 32'd1);

        // Even then odd parity on 0xA5 (four ones).
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        fs = frames_seen;
        send(8'hA5, 1'b1, 1'b0);
        wait_frames(fs + 1, 200);
        PAR_TYP = 1'b1;
        send(8'hA5, 1'b1, 1'b1);
        wait_frames(fs + 2, 200);

        // Back-to-back frames.
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        rd0 = rd_cnt; fs = frames_seen;
        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        wait_frames(fs + 2, 300);
        check("b2b_gap_cycles", 32'(last_gap), 32'd2);
        check("b2b_busy_low_in_gap", 32'(last_gap_low), 32'd0);
        check("b2b_rd_req_count", 32'(rd_cnt - rd0), 32'd2);

        // Missing data: D_Valid withheld, DUT retries FETCH without sending.
        drop_valid = 1'b1;
        rd0 = rd_cnt; done0 = done_cnt; txl0 = tx_low_cnt; fs = frames_seen;
        send(8'h5A, 1'b0, 1'b0);
        repeat (12) @(negedge CLK);
        check("missing_refetch", 32'(rd_cnt - rd0 >= 2), 32'd1);
        check("missing_tx_quiet", 32'(tx_low_cnt - txl0), 32'd0);
        check("missing_no_done", 32'(done_cnt - done0), 32'd0);
        drop_valid = 1'b0;
        wait_frames(fs + 1, 200);

        // Parity config toggled mid-frame only affects the next frame.
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        fs = frames_seen;
        send(8'h3C, 1'b1, 1'b1);
        n = 0;
        while (mon_busy !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        repeat (10) @(negedge CLK);
        PAR_EN = 1'b0;
        wait_frames(fs + 1, 200);
        send(8'h07, 1'b0, 1'b0);
        wait_frames(fs + 2, 200);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
